// File: rtl/mux2_share_arbiter_if.sv
// rtl/mux2_share_arbiter_if.sv - request/data/grant bundle of the shared 2:1 path
// Purpose : groups the two requester handshakes and the shared muxed output.
// Signals : req_a/req_b, data_a/data_b    requester side (driven by master)
//           gnt_a/gnt_b, sel               grants and shared select (driven by slave)
//           out_data/out_valid             registered muxed beat (driven by slave)
// Modports: master = requesters + consumer, slave = arbiter.
interface mux2_share_arbiter_if #(
  parameter int DATA_W = 1
);
  logic              req_a;
  logic              req_b;
  logic [DATA_W-1:0] data_a;
  logic [DATA_W-1:0] data_b;
  logic              gnt_a;
  logic              gnt_b;
  logic              sel;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;

  modport master (
    output req_a, req_b, data_a, data_b,
    input  gnt_a, gnt_b, sel, out_data, out_valid
  );

  modport slave (
    input  req_a, req_b, data_a, data_b,
    output gnt_a, gnt_b, sel, out_data, out_valid
  );
endinterface

// File: rtl/mux2_share_arbiter.sv
// rtl/mux2_share_arbiter.sv - round-robin arbiter sharing one 2:1 datapath between A and B
// Purpose : grants the shared path to A or B with a bounded burst, drives the
//           select, and registers the muxed beat with a valid flag.
// Ports   : clk    rising-edge clock
//           rst_n  asynchronous active-low reset
//           bus    mux2_share_arbiter_if.slave (req/data in, gnt/sel/out_data/out_valid out)
// Option  : ARB_DEAD_CYCLE_EN inserts one SWITCH cycle on every direct A<->B handover.
module mux2_share_arbiter #(
  parameter int DATA_W    = 1,
  parameter int MAX_BURST = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  mux2_share_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    OWN_A  = 2'd1,
    OWN_B  = 2'd2
`ifdef ARB_DEAD_CYCLE_EN
    ,SWITCH = 2'd3
`endif
  } state_t;

  localparam logic [7:0] CNT_MAX = 8'(MAX_BURST - 1);

  // Target of a direct owner handover; with the dead cycle, SWITCH sits in
  // between and last_owner already names the incoming owner.
`ifdef ARB_DEAD_CYCLE_EN
  localparam state_t A_TO_B = SWITCH;
  localparam state_t B_TO_A = SWITCH;
`else
  localparam state_t A_TO_B = OWN_B;
  localparam state_t B_TO_A = OWN_A;
`endif

  state_t            state_q, state_d;
  logic [7:0]        cnt_q, cnt_d, cnt_inc;
  logic              last_b_q, last_b_d;   // 1: B owned last, so A wins a tie
  logic              sel_q, sel_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              out_valid_q, out_valid_d;
  logic              gnt_a, gnt_b, xfer;

  // State register and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= 8'd0;
      last_b_q    <= 1'b1;
      sel_q       <= 1'b0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      last_b_q    <= last_b_d;
      sel_q       <= sel_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    last_b_d = last_b_q;
    cnt_inc  = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 8'd1;
    case (state_q)
      IDLE: begin
        if (bus.req_a && (!bus.req_b || last_b_q)) begin
          state_d = OWN_A; cnt_d = 8'd0; last_b_d = 1'b0;
        end else if (bus.req_b) begin
          state_d = OWN_B; cnt_d = 8'd0; last_b_d = 1'b1;
        end
      end
      OWN_A: begin
        // A dropping its request takes priority over preemption; both end the same way.
        if (!bus.req_a) begin
          if (bus.req_b) begin
            state_d = A_TO_B; cnt_d = 8'd0; last_b_d = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end else if (bus.req_b && (cnt_q == CNT_MAX)) begin
          state_d = A_TO_B; cnt_d = 8'd0; last_b_d = 1'b1;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      OWN_B: begin
        if (!bus.req_b) begin
          if (bus.req_a) begin
            state_d = B_TO_A; cnt_d = 8'd0; last_b_d = 1'b0;
          end else begin
            state_d = IDLE;
          end
        end else if (bus.req_a && (cnt_q == CNT_MAX)) begin
          state_d = B_TO_A; cnt_d = 8'd0; last_b_d = 1'b0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
`ifdef ARB_DEAD_CYCLE_EN
      SWITCH: begin
        state_d = last_b_q ? OWN_B : OWN_A;
        cnt_d   = 8'd0;
      end
`endif
      default: state_d = IDLE;
    endcase

    // Select follows the owner being entered; IDLE keeps the last path selected.
    case (state_d)
      OWN_A:   sel_d = 1'b0;
      OWN_B:   sel_d = 1'b1;
      IDLE:    sel_d = sel_q;
      default: sel_d = last_b_d;
    endcase
  end

  // Output logic: grants decode the state register; the beat uses the shared mux.
  always_comb begin
    gnt_a       = (state_q == OWN_A);
    gnt_b       = (state_q == OWN_B);
    xfer        = (bus.req_a & gnt_a) | (bus.req_b & gnt_b);
    out_valid_d = xfer;
    out_data_d  = out_data_q;
    if (xfer) begin
      out_data_d = sel_q ? bus.data_b : bus.data_a;
    end
  end

  assign bus.gnt_a     = gnt_a;
  assign bus.gnt_b     = gnt_b;
  assign bus.sel       = sel_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_valid = out_valid_q;

endmodule

// File: doc/mux2_share_arbiter.md
Name: mux2_share_arbiter

Overview:
- Round-robin arbiter that shares one 2:1 select datapath (out = S ? B : A) between two requesters, A and B.
- Drives the select line, issues registered grants with a bounded burst length, and registers the muxed data with a valid flag.
- Sits between two producer blocks and a single downstream consumer of the shared path.

Parameters:
- DATA_W, 1, width of data_a, data_b and out_data.
- MAX_BURST, 4, maximum consecutive grant cycles for one owner while the other requests; legal range 1..255.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- req_a  input  1  requester A wants the path.
- req_b  input  1  requester B wants the path.
- data_a  input  DATA_W  requester A data.
- data_b  input  DATA_W  requester B data.
- gnt_a  output  1  A owns the path.
- gnt_b  output  1  B owns the path.
- sel  output  1  shared select: 0 = A, 1 = B.
- out_data  output  DATA_W  registered muxed data.
- out_valid  output  1  out_data holds a transferred beat.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low. Asserting rst_n=0 forces outputs immediately, with no clock edge needed: gnt_a=0, gnt_b=0, sel=0, out_valid=0, out_data=0.
- Internal reset state: state=IDLE, burst counter=0, last_owner=B, so A wins the first tie.
- States: IDLE, OWN_A, OWN_B (plus SWITCH under the optional macro).
- Outputs are Moore, driven from registers: gnt_a=(state==OWN_A), gnt_b=(state==OWN_B). sel=0 in OWN_A, 1 in OWN_B, and holds its last value in IDLE.
- IDLE transitions:
  - only req_a → OWN_A.
  - only req_b → OWN_B.
  - both → the owner that is not last_owner.
  - none → stay in IDLE.
- Entering an owner state: counter=0 and last_owner is updated.
- OWN_A, evaluated each edge (OWN_B is symmetric):
  - req_a=0 and req_b=1 → OWN_B.
  - req_a=0 and req_b=0 → IDLE.
  - req_a=1, req_b=1 and counter==MAX_BURST-1 → OWN_B (preemption).
  - otherwise stay and increment the counter, saturating at MAX_BURST-1.
- Lone requester: never preempted; holds the grant indefinitely.
- MAX_BURST=1 with both requesting: ownership alternates every cycle.
- Transfer rule: a beat transfers on an edge where (req_a & gnt_a) or (req_b & gnt_b).
  - On that edge: out_valid<=1 and out_data<=the granted requester's data.
  - Otherwise out_valid<=0 and out_data holds its value.
- Latency: request to grant is 1 cycle; transfer to out_data/out_valid is 1 cycle.
- Grant lag after req drop: gnt may stay high one cycle after req drops. That cycle is not a transfer.
- Simultaneous events: req drop and preemption on the same edge → the drop rule applies first; the result is identical (switch to other or IDLE).
- Reset mid-burst: everything returns to the reset values above; the arbitration history is lost (last_owner=B).

Optional Feature:
- Macro: ARB_DEAD_CYCLE_EN.
- Defined:
  - Every direct OWN_A↔OWN_B switch passes through one SWITCH cycle with gnt_a=gnt_b=0 and out_valid=0.
  - sel takes the new owner's value during SWITCH.
  - The new owner's grant follows on the next edge.
  - Switching from IDLE has no dead cycle.
- Undefined: the SWITCH state does not exist; switches are direct, with zero gap.

Test Plan:
- Reset: hold rst_n=0 with req_a=req_b=1 → gnt_a=gnt_b=0, sel=0, out_valid=0, out_data=0 throughout. Drop rst_n asynchronously mid-cycle → outputs go to zero without waiting for a clock edge.
- Lone requester: req_a=1, data_a=1 for 10 cycles, req_b=0 →
  - gnt_a=1 from edge 1; out_valid=1, out_data=1 from edge 2.
  - sel=0 and no grant drop across all 10 cycles.
- Fair sharing, MAX_BURST=4: req_a=req_b=1 after reset, data_a=0, data_b=1 →
  - gnt_a for exactly 4 cycles, then gnt_b with sel=1 for 4 cycles, repeating.
  - out_data follows the same pattern one cycle later.
- Early release: B owns the path, counter=1, req_b drops while req_a=1 → gnt_a=1 on the next edge, and A then gets a full 4-cycle burst.
- Mid-burst reset: pulse rst_n=0 during OWN_B with both requesting → all outputs immediately 0; after release, A is granted first.
- Macro defined, MAX_BURST=2, both requesting → sequence gnt_a,gnt_a,dead,gnt_b,gnt_b,dead,…; sel flips during each dead cycle.
